// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//   Parametrised serial pattern detector. Each accepted bit of x is shifted into
//   a history register. z pulses for one cycle after the edge whose bit makes
//   the last LEN accepted bits equal PATTERN. The oldest bit is the MSB.
//
//   Matching is gated by a fill counter, not by the history contents. A match
//   is possible only after LEN valid bits have been taken since reset, clr, or
//   a non-overlapping match. Zero-filled history therefore never produces a
//   false match, even when PATTERN is all zeros.
//
// Parameters
//   LEN      pattern length in bits, 2..32
//   PATTERN  target pattern; only bits [LEN-1:0] are used, MSB is oldest
//   OVERLAP  1: consecutive matches may share bits
//            0: a match restarts filling from zero
//   CNT_W    match counter width (only with SEQ_MATCH_CNT_EN)
//
// Optional feature macro: SEQ_MATCH_CNT_EN
//   When defined, adds the saturating match_cnt output. rst_n is the only
//   thing that clears it.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   x          in   1      serial data bit
//   x_valid    in   1      x is accepted on a rising edge only when 1
//   clr        in   1      synchronous clear of history, fill state and z;
//                          has priority over x_valid
//   z          out  1      registered one-cycle match pulse
//   armed      out  1      fill has reached LEN-1, so the next bit can complete
//                          a match
//   match_cnt  out  CNT_W  saturating match count (SEQ_MATCH_CNT_EN only)
// -----------------------------------------------------------------------------
module seq_detect_param #(
  parameter int unsigned LEN     = 4,
  parameter logic [31:0] PATTERN = 32'h0000_000B,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             clr,
  output logic             z,
`ifdef SEQ_MATCH_CNT_EN
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
`else
  output logic             armed
`endif
);

  // Fill counter spans 0..LEN-1.
  localparam int unsigned    FW       = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [FW-1:0]  FILL_MAX = FW'(LEN - 1);
  localparam logic [FW-1:0]  FILL_ONE = FW'(1);
  localparam logic [FW-1:0]  FILL_ZERO = {FW{1'b0}};
  localparam logic [LEN-1:0] PAT      = PATTERN[LEN-1:0];

  generate
    if ((LEN < 2) || (LEN > 32)) begin : g_bad_len
      $error("seq_detect_param: LEN must be within 2..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("seq_detect_param: CNT_W must be at least 1");
    end
  endgenerate

  // The two regions of the fill-counter state.
  typedef enum logic {
    REGION_FILL  = 1'b0,
    REGION_ARMED = 1'b1
  } region_e;

  // The history keeps only the newest LEN-1 bits. The incoming x supplies the
  // LSB of the LEN-bit candidate.
  logic [LEN-2:0] hist_r;
  logic [LEN-2:0] hist_nxt_s;
  logic [FW-1:0]  fill_r;
  logic [FW-1:0]  fill_nxt_s;
  logic           z_r;
  logic           z_nxt_s;
  logic [LEN-1:0] cand_s;
  logic           hit_s;
  region_e        region_s;

  // Region decode from the registered fill value.
  always_comb begin
    region_s = REGION_FILL;
    if (fill_r == FILL_MAX) begin
      region_s = REGION_ARMED;
    end else begin
      region_s = REGION_FILL;
    end
  end

  // Next-state logic: clr wins, then x_valid accepts a bit, otherwise hold.
  always_comb begin
    cand_s     = {hist_r, x};
    hist_nxt_s = hist_r;
    fill_nxt_s = fill_r;
    hit_s      = 1'b0;
    z_nxt_s    = 1'b0;
    if (clr) begin
      hist_nxt_s = {(LEN-1){1'b0}};
      fill_nxt_s = FILL_ZERO;
    end else if (x_valid) begin
      hist_nxt_s = cand_s[LEN-2:0];
      case (region_s)
        REGION_ARMED: begin
          if (cand_s == PAT) begin
            hit_s = 1'b1;
            // Non-overlap mode restarts the fill. The stale history is then
            // overwritten before it can take part in another compare.
            if (OVERLAP) begin
              fill_nxt_s = FILL_MAX;
            end else begin
              fill_nxt_s = FILL_ZERO;
            end
          end else begin
            fill_nxt_s = FILL_MAX;
          end
        end
        REGION_FILL: begin
          fill_nxt_s = fill_r + FILL_ONE;
        end
        default: begin
          fill_nxt_s = FILL_ZERO;
        end
      endcase
    end else begin
      hist_nxt_s = hist_r;
      fill_nxt_s = fill_r;
    end
    z_nxt_s = hit_s;
  end

  // State registers: history, fill counter and match pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= {(LEN-1){1'b0}};
      fill_r <= FILL_ZERO;
      z_r    <= 1'b0;
    end else begin
      hist_r <= hist_nxt_s;
      fill_r <= fill_nxt_s;
      z_r    <= z_nxt_s;
    end
  end

  assign z     = z_r;
  assign armed = (region_s == REGION_ARMED);

`ifdef SEQ_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] match_cnt_r;
  logic [CNT_W-1:0] match_cnt_nxt_s;

  // Saturating increment on every hit. clr does not clear the count.
  always_comb begin
    match_cnt_nxt_s = match_cnt_r;
    if (hit_s && (match_cnt_r != CNT_MAX)) begin
      match_cnt_nxt_s = match_cnt_r + CNT_ONE;
    end else begin
      match_cnt_nxt_s = match_cnt_r;
    end
  end

  // Match counter register; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt_r <= {CNT_W{1'b0}};
    end else begin
      match_cnt_r <= match_cnt_nxt_s;
    end
  end

  assign match_cnt = match_cnt_r;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//   Directed bench for seq_detect_param. All instances share one input stream:
//     u_ov  : LEN=4, PATTERN=1011, OVERLAP=1
//     u_no  : LEN=4, PATTERN=1011 with junk upper bits, OVERLAP=0
//     u_sat : LEN=4, PATTERN=1011, OVERLAP=1, CNT_W=2
//     u_zr  : LEN=3, PATTERN=000,  OVERLAP=1
//   Inputs change on the falling edge. Outputs are sampled 1 time unit after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst_n;
  logic x;
  logic x_valid;
  logic clr;

  logic z_ov, armed_ov;
  logic z_no, armed_no;
  logic z_sat, armed_sat;
  logic z_zr, armed_zr;
`ifdef SEQ_MATCH_CNT_EN
  logic [7:0] cnt_ov;
  logic [7:0] cnt_no;
  logic [1:0] cnt_sat;
  logic [7:0] cnt_zr;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.LEN(4), .PATTERN(32'h0000_000B), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .clr(clr),
    .z(z_ov),
`ifdef SEQ_MATCH_CNT_EN
    .armed(armed_ov), .match_cnt(cnt_ov)
`else
    .armed(armed_ov)
`endif
  );

  seq_detect_param #(.LEN(4), .PATTERN(32'hA5A5_A5AB), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .clr(clr),
    .z(z_no),
`ifdef SEQ_MATCH_CNT_EN
    .armed(armed_no), .match_cnt(cnt_no)
`else
    .armed(armed_no)
`endif
  );

  seq_detect_param #(.LEN(4), .PATTERN(32'h0000_000B), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .clr(clr),
    .z(z_sat),
`ifdef SEQ_MATCH_CNT_EN
    .armed(armed_sat), .match_cnt(cnt_sat)
`else
    .armed(armed_sat)
`endif
  );

  seq_detect_param #(.LEN(3), .PATTERN(32'h0000_0000), .OVERLAP(1'b1), .CNT_W(8)) u_zr (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .clr(clr),
    .z(z_zr),
`ifdef SEQ_MATCH_CNT_EN
    .armed(armed_zr), .match_cnt(cnt_zr)
`else
    .armed(armed_zr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic b);
    @(negedge clk);
    x = b; x_valid = 1'b1; clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic b);
    @(negedge clk);
    x = b; x_valid = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drive clr together with a valid 1 to show that clr takes priority.
  task automatic do_clr();
    @(negedge clk);
    x = 1'b1; x_valid = 1'b1; clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; x_valid = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; x = 1'b0; x_valid = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_z_ov", {31'd0, z_ov}, 32'd0);
    chk("rst_armed_ov", {31'd0, armed_ov}, 32'd0);
    chk("rst_z_no", {31'd0, z_no}, 32'd0);
    chk("rst_armed_zr", {31'd0, armed_zr}, 32'd0);
`ifdef SEQ_MATCH_CNT_EN
    chk("rst_cnt_ov", {24'd0, cnt_ov}, 32'd0);
    chk("rst_cnt_sat", {30'd0, cnt_sat}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Zero pattern with LEN=3: the first two zeros must not match.
    feed(1'b0);
    chk("zr_b1_z", {31'd0, z_zr}, 32'd0);
    chk("zr_b1_armed", {31'd0, armed_zr}, 32'd0);
    feed(1'b0);
    chk("zr_b2_z", {31'd0, z_zr}, 32'd0);
    chk("zr_b2_armed", {31'd0, armed_zr}, 32'd1);
    feed(1'b0);
    chk("zr_b3_z", {31'd0, z_zr}, 32'd1);
    do_reset();

    // Tests 1-3: stream 1,0,1,1,0,1,1.
    feed(1'b1);
    chk("t1_b1_z", {31'd0, z_ov}, 32'd0);
    chk("t1_b1_armed", {31'd0, armed_ov}, 32'd0);
    feed(1'b0);
    chk("t1_b2_armed", {31'd0, armed_ov}, 32'd0);
    feed(1'b1);
    chk("t1_b3_z", {31'd0, z_ov}, 32'd0);
    chk("t1_b3_armed", {31'd0, armed_ov}, 32'd1);
    chk("t3_b3_armed_no", {31'd0, armed_no}, 32'd1);
    feed(1'b1);
    chk("t1_b4_z_ov", {31'd0, z_ov}, 32'd1);
    chk("t3_b4_z_no", {31'd0, z_no}, 32'd1);
    chk("t2_b4_armed_ov", {31'd0, armed_ov}, 32'd1);
    chk("t3_b4_armed_no", {31'd0, armed_no}, 32'd0);
    feed(1'b0);
    chk("t2_b5_z_ov", {31'd0, z_ov}, 32'd0);
    feed(1'b1);
    chk("t2_b6_z_ov", {31'd0, z_ov}, 32'd0);
    feed(1'b1);
    chk("t2_b7_z_ov", {31'd0, z_ov}, 32'd1);
    chk("t3_b7_z_no", {31'd0, z_no}, 32'd0);
    chk("t3_b7_armed_no", {31'd0, armed_no}, 32'd1);
    hold(1'b0);
    chk("t2_pulse_end", {31'd0, z_ov}, 32'd0);
`ifdef SEQ_MATCH_CNT_EN
    chk("t2_cnt_ov", {24'd0, cnt_ov}, 32'd2);
    chk("t3_cnt_no", {24'd0, cnt_no}, 32'd1);
`endif

    // Test 4: bits held while x_valid=0 change nothing.
    do_clr();
    chk("t4_clr_armed", {31'd0, armed_ov}, 32'd0);
    chk("t4_clr_z", {31'd0, z_ov}, 32'd0);
    feed(1'b1);
    feed(1'b0);
    for (int i = 0; i < 5; i++) begin
      hold(i[0]);
      chk("t4_hold_z", {31'd0, z_ov}, 32'd0);
      chk("t4_hold_armed", {31'd0, armed_ov}, 32'd0);
    end
    feed(1'b1);
    chk("t4_b3_armed", {31'd0, armed_ov}, 32'd1);
    chk("t4_b3_z", {31'd0, z_ov}, 32'd0);
    feed(1'b1);
    chk("t4_b4_z_ov", {31'd0, z_ov}, 32'd1);
    chk("t4_b4_z_no", {31'd0, z_no}, 32'd1);

    // Test 5: clr drops the partial history 1,0,1.
    do_clr();
    feed(1'b1);
    feed(1'b0);
    feed(1'b1);
    chk("t5_pre_armed", {31'd0, armed_ov}, 32'd1);
    do_clr();
    chk("t5_clr_armed", {31'd0, armed_ov}, 32'd0);
    chk("t5_clr_z", {31'd0, z_ov}, 32'd0);
    feed(1'b1);
    chk("t5_a1_z", {31'd0, z_ov}, 32'd0);
    chk("t5_a1_armed", {31'd0, armed_ov}, 32'd0);
    feed(1'b0);
    chk("t5_a2_z", {31'd0, z_ov}, 32'd0);
    feed(1'b1);
    chk("t5_a3_z", {31'd0, z_ov}, 32'd0);
    chk("t5_a3_armed", {31'd0, armed_ov}, 32'd1);
    feed(1'b1);
    chk("t5_a4_z_ov", {31'd0, z_ov}, 32'd1);
    chk("t5_a4_z_no", {31'd0, z_no}, 32'd1);
`ifdef SEQ_MATCH_CNT_EN
    chk("t5_cnt_ov_kept", {24'd0, cnt_ov}, 32'd4);
    chk("t5_cnt_no_kept", {24'd0, cnt_no}, 32'd3);
    chk("t5_cnt_sat", {30'd0, cnt_sat}, 32'd3);
`endif

    // Test 6: five overlapping matches, then an async reset mid-stream.
    do_reset();
`ifdef SEQ_MATCH_CNT_EN
    chk("t6_rst_cnt_sat", {30'd0, cnt_sat}, 32'd0);
`endif
    feed(1'b1);
    feed(1'b0);
    feed(1'b1);
    feed(1'b1);
    chk("t6_m1_z", {31'd0, z_sat}, 32'd1);
`ifdef SEQ_MATCH_CNT_EN
    chk("t6_m1_cnt_sat", {30'd0, cnt_sat}, 32'd1);
`endif
    for (int k = 0; k < 4; k++) begin
      feed(1'b0);
      chk("t6_gap_z", {31'd0, z_ov}, 32'd0);
      feed(1'b1);
      feed(1'b1);
      chk("t6_m_z", {31'd0, z_ov}, 32'd1);
`ifdef SEQ_MATCH_CNT_EN
      chk("t6_cnt_sat", {30'd0, cnt_sat}, (k + 2 > 3) ? 32'd3 : 32'(k + 2));
      chk("t6_cnt_ov", {24'd0, cnt_ov}, 32'(k + 2));
`endif
    end
    chk("t6_pre_armed", {31'd0, armed_ov}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_z_ov", {31'd0, z_ov}, 32'd0);
    chk("t6_async_armed_ov", {31'd0, armed_ov}, 32'd0);
    chk("t6_async_z_sat", {31'd0, z_sat}, 32'd0);
`ifdef SEQ_MATCH_CNT_EN
    chk("t6_async_cnt_sat", {30'd0, cnt_sat}, 32'd0);
    chk("t6_async_cnt_ov", {24'd0, cnt_ov}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
